ifetch_redirect: RTL and testbench

- Instruction-fetch front end for the LEGv8 core.
- Holds the architectural PC and issues requests to instruction memory over a req/ack handshake.
- Presents fetched instructions to decode over a valid/ready handshake.
- Consumes execute-stage branch resolution (branch_target, zero, branch type) and redirects the PC, discarding wrong-path fetches.

---
 rtl/ifetch_redirect_if.sv | 25 ++
 rtl/ifetch_redirect.sv | 159 +++++++++++++++
 tb/tb_ifetch_redirect.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_redirect_if.sv
// Fetch-unit bus: instruction-memory req/ack channel plus the valid/ready channel to decode.
// master = fetch unit, slave = memory/decode side.
interface ifetch_redirect_if #(
    parameter int unsigned WORD    = 64,
    parameter int unsigned INSTR_W = 32
);
    logic               imem_req;
    logic [WORD-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               if_valid;
    logic [INSTR_W-1:0] if_instr;
    logic [WORD-1:0]    if_pc;
    logic               if_ready;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc,
        input  imem_ack, imem_rdata, if_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc,
        output imem_ack, imem_rdata, if_ready
    );
endinterface

// File: rtl/ifetch_redirect.sv
// LEGv8 instruction-fetch front end: holds the PC, fetches over req/ack, presents
// instructions to decode over valid/ready and redirects on taken branches (CBZ/B).
// Optional perf counters (taken_count, fetch_count) are built when IFETCH_PERF_CNT_EN is defined.
module ifetch_redirect #(
    parameter int unsigned     WORD     = 64,
    parameter logic [WORD-1:0] RESET_PC = '0,
    parameter int unsigned     INSTR_W  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            ex_valid,
    input  logic            ex_branch,
    input  logic            ex_uncond,
    input  logic            ex_zero,
    input  logic [WORD-1:0] ex_branch_target,
    ifetch_redirect_if.master fetch_bus,
    output logic            flush
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]     taken_count,
    output logic [31:0]     fetch_count
`endif
);

    typedef enum logic [1:0] {StIdle, StReq, StOut} state_e;

    state_e             state_q, state_d;
    logic [WORD-1:0]    pc_q, pc_d;
    logic [WORD-1:0]    req_addr_q, req_addr_d;
    logic               drop_q, drop_d;
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [WORD-1:0]    if_pc_q, if_pc_d;

    logic               taken;
    logic               accept;
    logic [WORD-1:0]    redir;
    logic [WORD-1:0]    pc_next;

    assign taken   = ex_valid & (ex_uncond | (ex_branch & ex_zero));
    assign flush   = taken;
    assign redir   = {ex_branch_target[WORD-1:2], 2'b00};
    assign pc_next = pc_q + WORD'(4);

    assign fetch_bus.imem_req  = (state_q == StReq);
    assign fetch_bus.imem_addr = req_addr_q;
    assign fetch_bus.if_valid  = valid_q;
    assign fetch_bus.if_instr  = instr_q;
    assign fetch_bus.if_pc     = if_pc_q;

    // Next-state logic: fetch sequencing, redirect and wrong-path discard.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        drop_d     = drop_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        if_pc_d    = if_pc_q;
        accept     = 1'b0;
        unique case (state_q)
            StIdle: begin
                state_d = StReq;
                if (taken) begin
                    pc_d       = redir;
                    req_addr_d = redir;
                end else begin
                    req_addr_d = pc_q;
                end
            end
            StReq: begin
                if (fetch_bus.imem_ack) begin
                    if (drop_q || taken) begin
                        // Wrong-path data: discard and reissue at the (possibly new) PC.
                        drop_d = 1'b0;
                        if (taken) begin
                            pc_d       = redir;
                            req_addr_d = redir;
                        end else begin
                            req_addr_d = pc_q;
                        end
                    end else begin
                        instr_d = fetch_bus.imem_rdata;
                        if_pc_d = req_addr_q;
                        valid_d = 1'b1;
                        state_d = StOut;
                    end
                end else if (taken) begin
                    // Address must stay stable until ack; remember to drop the response.
                    pc_d   = redir;
                    drop_d = 1'b1;
                end
            end
            StOut: begin
                if (taken) begin
                    pc_d       = redir;
                    req_addr_d = redir;
                    valid_d    = 1'b0;
                    state_d    = StReq;
                end else if (fetch_bus.if_ready && !stall) begin
                    accept     = 1'b1;
                    pc_d       = pc_next;
                    req_addr_d = pc_next;
                    valid_d    = 1'b0;
                    state_d    = StReq;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            drop_q     <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            if_pc_q    <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            drop_q     <= drop_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            if_pc_q    <= if_pc_d;
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] taken_cnt_q, fetch_cnt_q;

    assign taken_count = taken_cnt_q;
    assign fetch_count = fetch_cnt_q;

    // Saturating event counters for taken redirects and accepted decode handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt_q <= '0;
            fetch_cnt_q <= '0;
        end else begin
            if (taken && (taken_cnt_q != 32'hFFFF_FFFF)) begin
                taken_cnt_q <= taken_cnt_q + 32'd1;
            end
            if (accept && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
        end
    end
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_ifetch_redirect.sv
// Directed self-checking bench for ifetch_redirect.
module tb_ifetch_redirect;
    localparam int unsigned WORD    = 64;
    localparam int unsigned INSTR_W = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            stall;
    logic            ex_valid;
    logic            ex_branch;
    logic            ex_uncond;
    logic            ex_zero;
    logic [WORD-1:0] ex_branch_target;
    logic            flush;

    int n_checks = 0;
    int n_pass   = 0;

    ifetch_redirect_if #(.WORD(WORD), .INSTR_W(INSTR_W)) bus ();

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] taken_count;
    logic [31:0] fetch_count;
`endif

    ifetch_redirect #(
        .WORD    (WORD),
        .RESET_PC(64'd0),
        .INSTR_W (INSTR_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .ex_valid        (ex_valid),
        .ex_branch       (ex_branch),
        .ex_uncond       (ex_uncond),
        .ex_zero         (ex_zero),
        .ex_branch_target(ex_branch_target),
        .fetch_bus       (bus.master),
        .flush           (flush)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .taken_count     (taken_count),
        .fetch_count     (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic clear_ex();
        ex_valid = 1'b0; ex_branch = 1'b0; ex_uncond = 1'b0; ex_zero = 1'b0;
        ex_branch_target = '0;
    endtask

    // Called at a negedge; returns at the negedge where imem_req is seen.
    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus.imem_req) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    // Ack the pending request in its first cycle; returns at the negedge after the ack.
    task automatic serve(input logic [INSTR_W-1:0] instr, output bit ok);
        wait_req(ok);
        if (ok) begin
            bus.imem_ack = 1'b1; bus.imem_rdata = instr;
            @(negedge clk);
            bus.imem_ack = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; clear_ex();
        bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.if_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        n_checks++; if (bus.imem_req !== 1'b0) $display("FAIL rst_req got %b want 0", bus.imem_req); else n_pass++;
        n_checks++; if (bus.imem_addr !== 64'd0) $display("FAIL rst_addr got %h want 0", bus.imem_addr); else n_pass++;
        n_checks++; if (bus.if_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", bus.if_valid); else n_pass++;
        n_checks++; if (bus.if_instr !== 32'd0) $display("FAIL rst_instr got %h want 0", bus.if_instr); else n_pass++;
        n_checks++; if (bus.if_pc !== 64'd0) $display("FAIL rst_pc got %h want 0", bus.if_pc); else n_pass++;
        ex_valid = 1'b1; ex_uncond = 1'b1; #1;
        n_checks++; if (flush !== 1'b1) $display("FAIL rst_flush_comb got %b want 1", flush); else n_pass++;
        clear_ex(); #1;
        n_checks++; if (flush !== 1'b0) $display("FAIL rst_flush_idle got %b want 0", flush); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sequential();
        bit ok;
        bus.if_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_req(ok);
            n_checks++; if (!ok) $display("FAIL seq_req_timeout got 0 want 1"); else n_pass++;
            n_checks++; if (bus.imem_addr !== 64'(i * 4)) $display("FAIL seq_addr got %h want %h", bus.imem_addr, 64'(i * 4)); else n_pass++;
            @(negedge clk);
            n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'(i * 4)) $display("FAIL seq_addr_hold got %b/%h want 1/%h", bus.imem_req, bus.imem_addr, 64'(i * 4)); else n_pass++;
            bus.imem_ack = 1'b1; bus.imem_rdata = 32'hA000_0000 + 32'(i);
            @(negedge clk);
            bus.imem_ack = 1'b0;
            n_checks++; if (bus.if_valid !== 1'b1) $display("FAIL seq_valid got %b want 1", bus.if_valid); else n_pass++;
            n_checks++; if (bus.if_pc !== 64'(i * 4)) $display("FAIL seq_if_pc got %h want %h", bus.if_pc, 64'(i * 4)); else n_pass++;
            n_checks++; if (bus.if_instr !== 32'hA000_0000 + 32'(i)) $display("FAIL seq_instr got %h want %h", bus.if_instr, 32'hA000_0000 + 32'(i)); else n_pass++;
            @(negedge clk);
            n_checks++; if (bus.if_valid !== 1'b0) $display("FAIL seq_valid_drop got %b want 0", bus.if_valid); else n_pass++;
        end
    endtask

    task automatic test_cbz_taken();
        bit ok;
        serve(32'h1111_000C, ok);
        @(negedge clk);
        bus.if_ready = 1'b0;
        serve(32'h1111_0010, ok);
        n_checks++; if (!ok || bus.if_pc !== 64'd16) $display("FAIL cbz_setup_pc got %h want 10", bus.if_pc); else n_pass++;
        ex_valid = 1'b1; ex_branch = 1'b1; ex_zero = 1'b1;
        ex_branch_target = 64'hFFFF_FFFF_FFFF_FFFE; #1;
        n_checks++; if (flush !== 1'b1) $display("FAIL cbz_flush got %b want 1", flush); else n_pass++;
        @(negedge clk);
        clear_ex();
        n_checks++; if (bus.if_valid !== 1'b0) $display("FAIL cbz_valid_kill got %b want 0", bus.if_valid); else n_pass++;
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL cbz_redir_addr got %b/%h want 1/fffffffffffffffc", bus.imem_req, bus.imem_addr); else n_pass++;
        bus.if_ready = 1'b1;
        serve(32'h2222_FFFC, ok);
        n_checks++; if (!ok || bus.if_pc !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL cbz_target_pc got %h want fffffffffffffffc", bus.if_pc); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'd0) $display("FAIL cbz_wrap_addr got %b/%h want 1/0", bus.imem_req, bus.imem_addr); else n_pass++;
    endtask

    task automatic test_b_pending();
        bit ok;
        bus.if_ready = 1'b0;
        serve(32'h3333_0000, ok);
        ex_valid = 1'b1; ex_uncond = 1'b1; ex_branch_target = 64'd28;
        @(negedge clk);
        clear_ex();
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'd28) $display("FAIL bp_req28 got %b/%h want 1/1c", bus.imem_req, bus.imem_addr); else n_pass++;
        ex_valid = 1'b1; ex_uncond = 1'b1; ex_branch_target = 64'd280; #1;
        n_checks++; if (flush !== 1'b1) $display("FAIL bp_flush got %b want 1", flush); else n_pass++;
        @(negedge clk);
        clear_ex();
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'd28) $display("FAIL bp_addr_hold got %b/%h want 1/1c", bus.imem_req, bus.imem_addr); else n_pass++;
        @(negedge clk);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        n_checks++; if (bus.if_valid !== 1'b0) $display("FAIL bp_drop_valid got %b want 0", bus.if_valid); else n_pass++;
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'd280) $display("FAIL bp_redir_addr got %b/%h want 1/118", bus.imem_req, bus.imem_addr); else n_pass++;
        serve(32'h4444_0118, ok);
        n_checks++; if (!ok || bus.if_valid !== 1'b1 || bus.if_pc !== 64'd280) $display("FAIL bp_target_fetch got %b/%h want 1/118", bus.if_valid, bus.if_pc); else n_pass++;
    endtask

    task automatic test_cbz_not_taken();
        ex_valid = 1'b0; ex_uncond = 1'b1; ex_branch_target = 64'd52; #1;
        n_checks++; if (flush !== 1'b0) $display("FAIL nt_exvalid0_flush got %b want 0", flush); else n_pass++;
        ex_valid = 1'b1; ex_uncond = 1'b0; ex_branch = 1'b1; ex_zero = 1'b0; #1;
        n_checks++; if (flush !== 1'b0) $display("FAIL nt_cbz_flush got %b want 0", flush); else n_pass++;
        bus.if_ready = 1'b1;
        @(negedge clk);
        clear_ex();
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'd284) $display("FAIL nt_seq_addr got %b/%h want 1/11c", bus.imem_req, bus.imem_addr); else n_pass++;
    endtask

    task automatic test_stall();
        bit ok;
        stall = 1'b1;
        serve(32'h5555_011C, ok);
        n_checks++; if (!ok || bus.if_valid !== 1'b1 || bus.if_pc !== 64'd284) $display("FAIL st_capture got %b/%h want 1/11c", bus.if_valid, bus.if_pc); else n_pass++;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 64'd284 || bus.if_instr !== 32'h5555_011C) $display("FAIL st_hold got %b/%h/%h want 1/11c/5555011c", bus.if_valid, bus.if_pc, bus.if_instr); else n_pass++;
            n_checks++; if (bus.imem_req !== 1'b0) $display("FAIL st_no_req got %b want 0", bus.imem_req); else n_pass++;
        end
        stall = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 64'd288) $display("FAIL st_advance got %b/%b/%h want 0/1/120", bus.if_valid, bus.imem_req, bus.imem_addr); else n_pass++;
    endtask

    task automatic test_back_to_back_taken_ready();
        bit ok;
`ifdef IFETCH_PERF_CNT_EN
        logic [31:0] tc0, fc0;
`endif
        bus.if_ready = 1'b0;
        serve(32'h6666_0120, ok);
        n_checks++; if (!ok || bus.if_pc !== 64'd288) $display("FAIL tr_setup_pc got %h want 120", bus.if_pc); else n_pass++;
`ifdef IFETCH_PERF_CNT_EN
        tc0 = taken_count; fc0 = fetch_count;
`endif
        bus.if_ready = 1'b1;
        ex_valid = 1'b1; ex_uncond = 1'b1; ex_branch_target = 64'h100; #1;
        n_checks++; if (flush !== 1'b1) $display("FAIL tr_flush got %b want 1", flush); else n_pass++;
        @(negedge clk);
        clear_ex();
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h100) $display("FAIL tr_addr got %b/%h want 1/100", bus.imem_req, bus.imem_addr); else n_pass++;
`ifdef IFETCH_PERF_CNT_EN
        n_checks++; if (taken_count - tc0 !== 32'd1) $display("FAIL tr_taken_cnt got %0d want %0d", taken_count, tc0 + 1); else n_pass++;
        n_checks++; if (fetch_count !== fc0) $display("FAIL tr_fetch_cnt got %0d want %0d", fetch_count, fc0); else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_cbz_taken();
        test_b_pending();
        test_cbz_not_taken();
        test_stall();
        test_back_to_back_taken_ready();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
